synapse_accumulator: RTL
========================

# synapse_accumulator

Weighted-synapse stage between the input neurons and the excitatory neuron. Once per time step it latches the vector of `Pre_spike` bits from the input-neuron array and walks the inputs sequentially. For each input that spiked, it adds that input's signed synaptic weight from a small register-file weight memory. The saturated sum is presented as `spiking_value`, with a one-cycle `sv_valid` strobe that drives the excitatory neuron's `en`.

## Interface
Parameters:
- `N_INPUTS`, 8, number of presynaptic input neurons (2..64).
- `W_WIDTH`, 16, signed weight and output width; matches the neuron's `spiking_value`.
- `ADDR_W`, 3, weight address width; must satisfy 2^ADDR_W ≥ N_INPUTS.

Ports:
- `clk`, in, 1, single clock.
- `rst`, in, 1, asynchronous, active-high reset.
- `en`, in, 1, time-step strobe; a one-cycle pulse starts an accumulation.
- `pre_spikes`, in, N_INPUTS, bit i is `Pre_spike` of input neuron i.
- `w_we`, in, 1, weight write enable.
- `w_addr`, in, ADDR_W, weight write address.
- `w_data`, in, W_WIDTH signed, weight write data.
- `spiking_value`, out, W_WIDTH signed, accumulated weighted input; held between steps.
- `sv_valid`, out, 1, one-cycle pulse when `spiking_value` is updated.
- `busy`, out, 1, high while an accumulation is in progress.
- `overrun`, out, 1, sticky flag: `en` arrived while busy.

## Operation
- FSM states: IDLE, ACCUM, DONE.
- IDLE, `en`=1:
  - latch `pre_spikes` into `spk_q`.
  - clear the accumulator `acc` (W_WIDTH+1 bits internal) and set `idx`=0.
  - go to ACCUM.
- ACCUM, each cycle:
  - if `spk_q[idx]`, `acc` ← sat(`acc` + `weight[idx]`).
  - `idx` increments.
  - when `idx` = N_INPUTS-1 has been processed, go to DONE.
- DONE, one cycle:
  - `spiking_value` ← `acc`.
  - `sv_valid`=1.
  - go to IDLE.
- Saturation is applied after every add:
  - a result > 2^(W_WIDTH-1)-1 clamps to 32767.
  - a result < -2^(W_WIDTH-1) clamps to -32768 (for W_WIDTH=16).
  - Once clamped, later adds continue from the clamped value.
- `en` in ACCUM or DONE is ignored (no restart) and sets `overrun`. Only `rst` clears `overrun`.
- Weight memory:
  - N_INPUTS × W_WIDTH flops, written when `w_we`=1 in any state.
  - A write and a read of the same index in the same cycle: the read returns the old weight; the new weight applies from the next step.
  - Weights are not reset (contents after reset are undefined until written). The bench must load all weights first.
- `w_addr` ≥ N_INPUTS: the write is dropped.
- All-zero `spk_q`: the full walk still runs; the output is 0 with `sv_valid` asserted.

## Timing
- Reset values: `spiking_value`=0, `sv_valid`=0, `busy`=0, `overrun`=0, FSM=IDLE, `acc`=0, `idx`=0.
- `en` sampled high at edge k: ACCUM covers edges k+1..k+N_INPUTS; `sv_valid` is high for the cycle after edge k+N_INPUTS+1. With N_INPUTS=8, `sv_valid` follows `en` by 9 cycles.
- `busy` is high from the cycle after `en` is sampled through the DONE cycle inclusive.
- Maximum step rate: one `en` every N_INPUTS+2 cycles. An `en` in the first IDLE cycle after DONE is accepted.
- `pre_spikes` is sampled only on the accepting edge; later changes do not affect the current step.
- `rst` mid-operation aborts immediately (asynchronous): outputs return to reset values and no `sv_valid` is produced.
- `spiking_value` changes only on the DONE edge or on reset.

## Structure
- Shared package `snn_pkg`: the FSM state enum (IDLE/ACCUM/DONE), `W_WIDTH`, `SAT_MAX`/`SAT_MIN` constants, and the signed weight typedef.
- One natural sub-module: `weight_regfile` (write port plus combinational read by `idx`).
- The saturating adder stays inline.

## Test plan
- Reset, load weights 0..7 = {100, 200, 300, 400, 500, 600, 700, 800}, `pre_spikes`=8'hFF, pulse `en` -> `spiking_value`=3600 with `sv_valid` exactly 9 cycles after `en`; `busy` high for 9 cycles.
- Weights as above, `pre_spikes`=8'b0000_0101 -> 400; `pre_spikes`=0 -> 0 with `sv_valid` still pulsed.
- All weights 16'sh7000, `pre_spikes`=8'hFF -> 32767. All weights -20000, `pre_spikes`=8'h03 -> -32768.
- Second `en` 3 cycles after the first -> ignored, `overrun`=1 and stays 1; the single result is unaffected. `en` one cycle after DONE -> accepted.
- Assert `rst` 4 cycles into ACCUM -> all outputs 0 at once, no `sv_valid`. The next `en` after release gives the correct sum.
- Write weight[2]=-50 at the same cycle `idx`=2 is read (old 300) -> the current step uses 300 and the next step uses -50. A write to `w_addr`=7 with N_INPUTS=6 -> no effect.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-network datapath blocks.
package snn_pkg;

    localparam int W_WIDTH = 16;
    localparam int SAT_MAX = (1 << (W_WIDTH - 1)) - 1;
    localparam int SAT_MIN = -(1 << (W_WIDTH - 1));

    typedef logic signed [W_WIDTH-1:0] weight_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/weight_regfile.sv
// Synaptic weight storage: one write port, combinational read by input index.
module weight_regfile
    import snn_pkg::*;
#(
    parameter int N_INPUTS = 8,
    parameter int W_WIDTH  = snn_pkg::W_WIDTH,
    parameter int ADDR_W   = 3
) (
    input  logic                      clk,
    input  logic                      w_we,
    input  logic [ADDR_W-1:0]         w_addr,
    input  logic signed [W_WIDTH-1:0] w_data,
    input  logic [ADDR_W-1:0]         rd_idx,
    output logic signed [W_WIDTH-1:0] rd_data
);

    logic signed [W_WIDTH-1:0] mem_q [N_INPUTS];
    logic signed [W_WIDTH-1:0] mem_d [N_INPUTS];

    // Addresses at or beyond N_INPUTS match no entry, so those writes drop.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < N_INPUTS; i++) begin
            if (w_we && (w_addr == ADDR_W'(i))) begin
                mem_d[i] = w_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/synapse_accumulator.sv
// Per-time-step weighted sum of presynaptic spikes with saturation, feeding
// the excitatory neuron's spiking_value/en.
module synapse_accumulator
    import snn_pkg::*;
#(
    parameter int N_INPUTS = 8,
    parameter int W_WIDTH  = snn_pkg::W_WIDTH,
    parameter int ADDR_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [N_INPUTS-1:0]       pre_spikes,
    input  logic                      w_we,
    input  logic [ADDR_W-1:0]         w_addr,
    input  logic signed [W_WIDTH-1:0] w_data,
    output logic signed [W_WIDTH-1:0] spiking_value,
    output logic                      sv_valid,
    output logic                      busy,
    output logic                      overrun
);

    localparam logic [ADDR_W-1:0]         LAST_IDX = ADDR_W'(N_INPUTS - 1);
    localparam logic signed [W_WIDTH:0]   SAT_HI   = {2'b00, {(W_WIDTH-1){1'b1}}};
    localparam logic signed [W_WIDTH:0]   SAT_LO   = {2'b11, {(W_WIDTH-1){1'b0}}};

    state_t                    state_q, state_d;
    logic [N_INPUTS-1:0]       spk_q, spk_d;
    logic signed [W_WIDTH:0]   acc_q, acc_d;
    logic [ADDR_W-1:0]         idx_q, idx_d;
    logic signed [W_WIDTH-1:0] sv_q, sv_d;
    logic                      sv_valid_q, sv_valid_d;
    logic                      overrun_q, overrun_d;

    logic signed [W_WIDTH-1:0] rd_weight;
    logic signed [W_WIDTH:0]   sum;
    logic signed [W_WIDTH:0]   sum_sat;

    weight_regfile #(
        .N_INPUTS (N_INPUTS),
        .W_WIDTH  (W_WIDTH),
        .ADDR_W   (ADDR_W)
    ) u_weights (
        .clk     (clk),
        .w_we    (w_we),
        .w_addr  (w_addr),
        .w_data  (w_data),
        .rd_idx  (idx_q),
        .rd_data (rd_weight)
    );

    // acc always holds a W_WIDTH-range value, so the one guard bit suffices:
    // overflow shows up as the top two bits of the sum disagreeing.
    always_comb begin
        sum     = acc_q + $signed({rd_weight[W_WIDTH-1], rd_weight});
        sum_sat = sum;
        if (sum[W_WIDTH] != sum[W_WIDTH-1]) begin
            sum_sat = sum[W_WIDTH] ? SAT_LO : SAT_HI;
        end
    end

    always_comb begin
        state_d    = state_q;
        spk_d      = spk_q;
        acc_d      = acc_q;
        idx_d      = idx_q;
        sv_d       = sv_q;
        sv_valid_d = 1'b0;
        overrun_d  = overrun_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    spk_d   = pre_spikes;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (en) begin
                    overrun_d = 1'b1;
                end
                if (spk_q[idx_q]) begin
                    acc_d = sum_sat;
                end
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (en) begin
                    overrun_d = 1'b1;
                end
                sv_d       = acc_q[W_WIDTH-1:0];
                sv_valid_d = 1'b1;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            spk_q      <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            sv_q       <= '0;
            sv_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            spk_q      <= spk_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            sv_q       <= sv_d;
            sv_valid_q <= sv_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign spiking_value = sv_q;
    assign sv_valid      = sv_valid_q;
    assign busy          = (state_q != IDLE);
    assign overrun       = overrun_q;

endmodule
